// File: rtl/memory_reader.sv
// Fetches one stored frame per request with a single INCR burst and replays the
// returned beats as an AXI-Stream master with tuser/tlast framing.
module memory_reader #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pixels_per_frame,
  input  logic [15:0]           frame_height,
  input  logic [15:0]           frame_width,
  input  logic                  frame_ready,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  output logic                  start_read,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic [31:0]           read_len,
  output logic [2:0]            read_size,
  output logic [1:0]            read_burst,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  read_valid,
  output logic                  read_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  frame_done,
  output logic [7:0]            dropped_frames
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] PtrOne = (PtrW + 1)'(1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] pend_base_q, pend_base_d;
  logic [7:0]            dropped_q, dropped_d;
  logic [31:0]           beats_in_q, beats_in_d;
  logic [31:0]           pix_out_q, pix_out_d;
  logic [15:0]           col_q, col_d;
  logic [15:0]           line_q, line_d;
  logic [PtrW:0]         wptr_q, wptr_d;
  logic [PtrW:0]         rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic fifo_full, fifo_empty, push, pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                      (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);

  assign read_ready = (state_q == STREAM) && !fifo_full && (beats_in_q < pixels_per_frame);
  assign push       = read_valid && read_ready;

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = m_axis_tvalid ? mem_q[rptr_q[PtrW-1:0]] : '0;
  assign m_axis_tuser  = m_axis_tvalid && (col_q == 16'd0) && (line_q == 16'd0);
  assign m_axis_tlast  = m_axis_tvalid && (col_q == frame_width - 16'd1);
  assign pop           = m_axis_tvalid && m_axis_tready;

  assign start_read     = (state_q == REQ);
  assign read_addr      = start_read ? base_q : '0;
  assign read_len       = start_read ? pixels_per_frame : 32'd0;
  assign read_size      = 3'd2;
  assign read_burst     = 2'd1;
  assign frame_done     = (state_q == DONE);
  assign dropped_frames = dropped_q;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    pend_d      = pend_q;
    pend_base_d = pend_base_q;
    dropped_d   = dropped_q;
    beats_in_d  = beats_in_q;
    pix_out_d   = pix_out_q;
    col_d       = col_q;
    line_d      = line_q;
    wptr_d      = push ? wptr_q + PtrOne : wptr_q;
    rptr_d      = pop ? rptr_q + PtrOne : rptr_q;

    // Requests arriving while busy are held; only the newest survives.
    if (frame_ready && (state_q != IDLE)) begin
      pend_d      = 1'b1;
      pend_base_d = base_addr_in;
      if (pend_q && (dropped_q != 8'hFF)) dropped_d = dropped_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (frame_ready) begin
          base_d  = base_addr_in;
          pend_d  = 1'b0;
          state_d = REQ;
          if (pend_q && (dropped_q != 8'hFF)) dropped_d = dropped_q + 8'd1;
        end else if (pend_q) begin
          base_d  = pend_base_q;
          pend_d  = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        beats_in_d = 32'd0;
        pix_out_d  = 32'd0;
        col_d      = 16'd0;
        line_d     = 16'd0;
        state_d    = STREAM;
      end
      STREAM: begin
        if (push) beats_in_d = beats_in_q + 32'd1;
        if (pop) begin
          pix_out_d = pix_out_q + 32'd1;
          if (col_q == frame_width - 16'd1) begin
            col_d  = 16'd0;
            line_d = line_q + 16'd1;
          end else begin
            col_d = col_q + 16'd1;
          end
          if (pix_out_q == pixels_per_frame - 32'd1) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      pend_q      <= 1'b0;
      pend_base_q <= '0;
      dropped_q   <= 8'd0;
      beats_in_q  <= 32'd0;
      pix_out_q   <= 32'd0;
      col_q       <= 16'd0;
      line_q      <= 16'd0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      pend_q      <= pend_d;
      pend_base_q <= pend_base_d;
      dropped_q   <= dropped_d;
      beats_in_q  <= beats_in_d;
      pix_out_q   <= pix_out_d;
      col_q       <= col_d;
      line_q      <= line_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[PtrW-1:0]] <= read_data;
  end

endmodule
